// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arb_pkg
//   Shared definitions for the CoreUART transmit arbiter:
//   - state_e  : arbiter FSM encoding (IDLE, LOAD, WAIT_ACK, WAIT_RDY)
//   - BYTE_W   : width of one transmitted byte
//   - CNT_W    : width of the accepted-byte counter
//   - clog2()  : constant function used to sanity-check ID_W against NUM_REQ
package uart_tx_arb_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    WAIT_ACK = 2'd2,
    WAIT_RDY = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_rr_pick
//   Purely combinational round-robin priority pick.
//   Ports:
//     eligible  in  NUM_REQ  requesters allowed to win this decision
//     ptr       in  ID_W     index with highest priority this decision
//     winner    out ID_W     first eligible index at or above ptr, with wrap
//     any_valid out 1        at least one requester is eligible
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  // Walk the candidates from lowest to highest priority so that the
  // highest-priority eligible index is the last one written.
  always_comb begin
    logic [ID_W-1:0] idx;
    winner = '0;
    idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (eligible[idx]) begin
        winner = idx;
      end
    end
  end

  assign any_valid = |eligible;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one CoreUART transmitter between NUM_REQ byte sources. A
//   round-robin winner's byte is loaded into the transmitter holding
//   register, tx_load pulses, and the FSM then follows txrdy (falling as
//   the byte is taken, rising when the transmitter can accept another).
//   A byte sent with req_last=0 locks the grant to that requester until
//   it sends a byte with req_last=1.
//   Ports:
//     clk, reset              clock, synchronous active-high reset
//     arb_en                  1 = new grants allowed
//     req_mask                1 = requester excluded from arbitration
//     req_valid/data/last     per-requester byte, data at [8i+7:8i]
//     req_ready               one-cycle accept pulse per requester
//     txrdy                   transmitter ready for a new byte
//     tx_hold_reg, tx_load    byte and load pulse to the transmitter
//     grant_id, busy, lock    arbitration status
//     err_timeout             sticky: txrdy never fell after tx_load
//     byte_cnt                bytes accepted, wrapping
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 255,
  parameter int ID_W        = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      arb_en,
  input  logic [NUM_REQ-1:0]        req_mask,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      txrdy,
  output logic [BYTE_W-1:0]         tx_hold_reg,
  output logic                      tx_load,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      lock,
  output logic                      err_timeout,
  output logic [CNT_W-1:0]          byte_cnt
);

  if (ID_W != clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_param
    $error("uart_tx_arbiter: ID_W must equal clog2(NUM_REQ), NUM_REQ in 2..8");
  end

  localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

  logic [BYTE_W-1:0] req_bytes [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_bytes[gi] = req_data[BYTE_W*gi +: BYTE_W];
  end

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [15:0]         tmo_q, tmo_d;
  logic [NUM_REQ-1:0]  ready_q, ready_d;
  logic [BYTE_W-1:0]   hold_q, hold_d;
  logic                load_q, load_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic                busy_q, busy_d;
  logic                lock_q, lock_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [NUM_REQ-1:0]  eligible;
  logic                lock_drop;
  logic [ID_W-1:0]     winner;
  logic                any_valid;

  // A masked lock owner loses the lock immediately, so the same IDLE
  // decision already arbitrates over the full unmasked set.
  always_comb begin
    lock_drop = lock_q && req_mask[grant_id_q];
    eligible  = req_valid & ~req_mask;
    if (lock_q && !lock_drop) begin
      eligible = eligible & (NUM_REQ'(1) << grant_id_q);
    end
  end

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .eligible  (eligible),
    .ptr       (ptr_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    tmo_d      = tmo_q;
    ready_d    = '0;
    hold_d     = hold_q;
    load_d     = 1'b0;
    grant_id_d = grant_id_q;
    lock_d     = lock_q;
    err_d      = err_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (lock_drop) begin
          lock_d = 1'b0;
        end
        if (arb_en && txrdy && any_valid) begin
          state_d         = LOAD;
          hold_d          = req_bytes[winner];
          ready_d[winner] = 1'b1;
          grant_id_d      = winner;
          cnt_d           = cnt_q + CNT_W'(1);
          lock_d          = ~req_last[winner];
          // Mid-message bytes keep the pointer so the message owner does
          // not lose its round-robin position once the message ends.
          if (req_last[winner]) begin
            ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          end
        end
      end
      LOAD: begin
        // tx_load is registered, so the pulse lands one cycle after the
        // holding register has settled.
        load_d  = 1'b1;
        tmo_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!txrdy) begin
          state_d = WAIT_RDY;
        end else begin
          tmo_d = tmo_q + 16'd1;
          if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            lock_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      WAIT_RDY: begin
        // No timeout here: the byte time depends on the baud rate.
        if (txrdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      tmo_q      <= '0;
      ready_q    <= '0;
      hold_q     <= '0;
      load_q     <= 1'b0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      tmo_q      <= tmo_d;
      ready_q    <= ready_d;
      hold_q     <= hold_d;
      load_q     <= load_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      lock_q     <= lock_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign req_ready   = ready_q;
  assign tx_hold_reg = hold_q;
  assign tx_load     = load_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign lock        = lock_q;
  assign err_timeout = err_q;
  assign byte_cnt    = cnt_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one CoreUART transmitter between NUM_REQ byte sources. It arbitrates round-robin, loads the winning byte into the transmitter's holding register, and pulses the transmitter's load/clear-empty input. It then sequences on the transmitter's txrdy until the byte is consumed. It sits between firmware or hardware byte producers and the Tx_async holding-register/txrdy interface, and optionally locks the grant across a multi-byte message.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ACK_TIMEOUT, 255, clk cycles to wait for txrdy to fall after tx_load before flagging an error (1..65535)
ID_W, 2, width of grant_id; must equal ceil(log2(NUM_REQ))

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
arb_en  in  1  1 = new grants allowed
req_mask  in  NUM_REQ  1 = requester excluded from arbitration
req_valid  in  NUM_REQ  requester i has a byte pending
req_data  in  8*NUM_REQ  byte of requester i at [8i+7:8i]
req_last  in  NUM_REQ  byte is last of a message (0 = hold the grant)
req_ready  out  NUM_REQ  one-cycle pulse: byte of requester i accepted
txrdy  in  1  transmitter ready for a new byte
tx_hold_reg  out  8  byte to transmitter holding register
tx_load  out  1  one-cycle load pulse (drives rst_tx_empty)
grant_id  out  ID_W  index of the last/current granted requester
busy  out  1  state != IDLE
lock  out  1  grant locked to grant_id mid-message
err_timeout  out  1  sticky: txrdy never fell after tx_load
byte_cnt  out  16  bytes accepted, wraps 16'hFFFF -> 0

Behaviour:
- All outputs are registered. Reset values: req_ready=0, tx_hold_reg=0, tx_load=0, grant_id=0, busy=0, lock=0, err_timeout=0, byte_cnt=0, state=IDLE, rr pointer=0, timeout counter=0.
- Reset is synchronous. Asserting it mid-operation aborts the byte in any state, clears lock, and returns to IDLE on the next edge. No tx_load is issued in the reset cycle.
- Eligible set E = req_valid & ~req_mask. When lock=1, E is restricted to requester grant_id.
- IDLE:
  - If arb_en & txrdy & |E: pick the first set bit of E searching from ptr upward with wrap (ptr = previous winner + 1 mod NUM_REQ).
  - At the edge: tx_hold_reg <= winner's byte; req_ready[winner] <= 1 for exactly one cycle; grant_id <= winner; byte_cnt += 1; state <= LOAD.
  - lock <= ~req_last[winner]. ptr <= winner+1 only when req_last[winner]=1; otherwise ptr is unchanged.
  - No grant is issued while txrdy=0.
- LOAD: tx_load=1 for this one cycle; state <= WAIT_ACK; clear the timeout counter.
- WAIT_ACK:
  - If txrdy=0, state <= WAIT_RDY.
  - Else the counter increments. When it reaches ACK_TIMEOUT: err_timeout <= 1, lock <= 0, state <= IDLE.
- WAIT_RDY: when txrdy=1, state <= IDLE. No timeout in this state, since baud-rate dependent.
- Minimum grant-to-grant spacing is 4 clk cycles: IDLE, LOAD, WAIT_ACK, WAIT_RDY.
- arb_en=0 blocks only new grants. An in-flight byte completes and lock is retained.
- If the locked requester becomes masked while in IDLE, lock clears at that edge and normal round-robin resumes in the same decision.
- req_valid dropping while locked does not release the lock; the block waits indefinitely.
- The requester must hold req_data stable while req_valid=1 until it sees req_ready. It may present its next byte in the cycle after req_ready.
- err_timeout clears only on reset.
- Simultaneous requests resolve by round-robin. A locked requester beats all others until it sends a byte with req_last=1.

Decomposition:
- Package uart_tx_arb_pkg: state encoding (IDLE, LOAD, WAIT_ACK, WAIT_RDY as 2-bit constants), BYTE_W=8, CNT_W=16, clog2 function for ID_W checks.
- One sub-module, uart_rr_pick: purely combinational round-robin priority pick. Inputs: eligible vector and ptr. Outputs: winner index and any-valid flag.
- The FSM, lock, counters and registers live in the top module.

Test Plan:
- Single byte: req_valid=4'b0001, req_data[7:0]=8'hA5, req_last=1, txrdy=1 -> next edge req_ready=4'b0001 and tx_hold_reg=8'hA5; one cycle later tx_load=1; model drops txrdy 1 cycle after tx_load, raises it 20 cycles later -> busy falls, byte_cnt=1.
- Round-robin: all four requesters valid continuously with req_last=1 -> grant_id sequence 0,1,2,3,0; no requester is skipped or granted twice in a row.
- Message lock: req0 sends 3 bytes (req_last=0,0,1) while req1 is valid throughout -> grants 0,0,0 then 1; lock=1 during bytes 1-2, 0 after byte 3.
- Mask and enable: lock held on req2, then req_mask[2]=1 in IDLE -> lock clears and req3 is granted; arb_en=0 mid-byte -> current byte completes, no further req_ready until arb_en=1.
- Timeout: txrdy held at 1 after tx_load, ACK_TIMEOUT=8 -> err_timeout=1 exactly 8 cycles into WAIT_ACK, state returns to IDLE, lock=0.
- Reset and wrap: assert reset in WAIT_RDY -> next edge busy=0, tx_load=0, lock=0, grant_id=0. Preload byte_cnt to 16'hFFFF via 65535 accepted bytes, then one more -> byte_cnt=0.
